aes128_round_ctrl: RTL and testbench

Sequencer for an iterative, round-reused AES-128 encryption datapath. It sits between the input message packer and the AES core. It:
- accepts four 32-bit plaintext/key word pairs,
- steps the datapath through the initial AddRoundKey and rounds 1..10, supplying the round number, Rcon and the final-round select,
- releases the four ciphertext words to the output packer under a valid/ready handshake.
It holds no cipher data, only control state.

---
 rtl/aes128_round_ctrl.sv | 159 +++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_ctrl.sv
// Control sequencer for a round-reused AES-128 datapath: load 4 words, ARK0, 10 rounds, unload 4 words.
// First ciphertext valid 2+10*ROUND_CYCLES cycles after the 4th load; output holds under out_ready_in=0.
`timescale 1ns/1ps
module aes128_round_ctrl #(
    parameter int ROUND_CYCLES = 1,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MP_dv_in,
    input  logic       out_ready_in,
    output logic       ld_en_out,
    output logic [1:0] ld_idx_out,
    output logic       ark0_en_out,
    output logic       round_en_out,
    output logic [3:0] round_num_out,
    output logic [7:0] rcon_out,
    output logic       final_round_out,
    output logic [1:0] out_idx_out,
    output logic       core_dv_out,
    output logic       busy_out,
    output logic       overrun_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARK0   = 3'd2,
        S_ROUND  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    localparam logic [3:0] LAST_SUB = 4'(ROUND_CYCLES - 1);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    generate
        if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
            $error("aes128_round_ctrl: NUM_ROUNDS must be 10 for AES-128");
        end
        if (ROUND_CYCLES < 1 || ROUND_CYCLES > 15) begin : g_bad_round_cycles
            $error("aes128_round_ctrl: ROUND_CYCLES must be in 1..15");
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_word_cnt;
    logic [1:0] w_word_cnt_nxt;
    logic [3:0] r_sub_cnt;
    logic [3:0] w_sub_cnt_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic [1:0] r_out_cnt;
    logic [1:0] w_out_cnt_nxt;
    logic       r_overrun;
    logic       w_accept;
    logic       w_commit;

    assign w_accept = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_commit = (r_state == S_ROUND) && (r_sub_cnt == LAST_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_word_cnt <= 2'd0;
            r_sub_cnt  <= 4'd0;
            r_round    <= 4'd0;
            r_out_cnt  <= 2'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_sub_cnt  <= w_sub_cnt_nxt;
            r_round    <= w_round_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_overrun  <= MP_dv_in && !w_accept;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_sub_cnt_nxt  = r_sub_cnt;
        w_round_nxt    = r_round;
        w_out_cnt_nxt  = r_out_cnt;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (MP_dv_in) begin
                    if (r_word_cnt == 2'd3) begin
                        w_state_nxt    = S_ARK0;
                        w_word_cnt_nxt = 2'd0;
                    end else begin
                        w_state_nxt    = S_LOAD;
                        w_word_cnt_nxt = r_word_cnt + 2'd1;
                    end
                end
            end
            S_ARK0: begin
                w_state_nxt   = S_ROUND;
                w_round_nxt   = 4'd1;
                w_sub_cnt_nxt = 4'd0;
            end
            S_ROUND: begin
                if (w_commit) begin
                    w_sub_cnt_nxt = 4'd0;
                    if (r_round < LAST_RND) begin
                        w_round_nxt = r_round + 4'd1;
                    end else begin
                        w_state_nxt   = S_OUTPUT;
                        w_out_cnt_nxt = 2'd0;
                    end
                end else begin
                    w_sub_cnt_nxt = r_sub_cnt + 4'd1;
                end
            end
            S_OUTPUT: begin
                if (out_ready_in) begin
                    w_out_cnt_nxt = r_out_cnt + 2'd1;
                    if (r_out_cnt == 2'd3) begin
                        w_state_nxt = S_IDLE;
                        w_round_nxt = 4'd0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ld_en_out is a Mealy output; gating with rst_n keeps it low while reset is held.
    always_comb begin
        ld_en_out       = MP_dv_in && w_accept && rst_n;
        ld_idx_out      = r_word_cnt;
        ark0_en_out     = (r_state == S_ARK0);
        round_en_out    = w_commit;
        round_num_out   = r_round;
        rcon_out        = 8'h00;
        final_round_out = (r_state == S_ROUND) && (r_round == LAST_RND);
        out_idx_out     = (r_state == S_OUTPUT) ? r_out_cnt : 2'd0;
        core_dv_out     = (r_state == S_OUTPUT);
        busy_out        = (r_state != S_IDLE);
        overrun_out     = r_overrun;
        if (r_state == S_ROUND) begin
            case (r_round)
                4'd1:    rcon_out = 8'h01;
                4'd2:    rcon_out = 8'h02;
                4'd3:    rcon_out = 8'h04;
                4'd4:    rcon_out = 8'h08;
                4'd5:    rcon_out = 8'h10;
                4'd6:    rcon_out = 8'h20;
                4'd7:    rcon_out = 8'h40;
                4'd8:    rcon_out = 8'h80;
                4'd9:    rcon_out = 8'h1B;
                4'd10:   rcon_out = 8'h36;
                default: rcon_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: two instances (ROUND_CYCLES 1 and 4) drive a behavioural AES datapath;
// ciphertext words and control timing are checked against a scoreboard filled at load time.
`timescale 1ns/1ps
module tb_aes128_round_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mp_dv, rdy, sel;
    logic [1:0] o_ld_en, o_ark0, o_ren, o_final, o_dv, o_busy, o_ovr;
    logic [1:0] o_ld_idx [2];
    logic [3:0] o_rnum   [2];
    logic [7:0] o_rcon   [2];
    logic [1:0] o_oidx   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes128_round_ctrl #(.ROUND_CYCLES(g == 0 ? 1 : 4), .NUM_ROUNDS(10)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .MP_dv_in(mp_dv && (sel == (g != 0))),
            .out_ready_in(rdy),
            .ld_en_out(o_ld_en[g]), .ld_idx_out(o_ld_idx[g]),
            .ark0_en_out(o_ark0[g]), .round_en_out(o_ren[g]),
            .round_num_out(o_rnum[g]), .rcon_out(o_rcon[g]),
            .final_round_out(o_final[g]), .out_idx_out(o_oidx[g]),
            .core_dv_out(o_dv[g]), .busy_out(o_busy[g]), .overrun_out(o_ovr[g])
        );
    end

    logic       m_ld_en, m_ark0, m_ren, m_final, m_dv, m_busy, m_ovr;
    logic [1:0] m_ld_idx, m_oidx;
    logic [3:0] m_rnum;
    logic [7:0] m_rcon;
    logic [22:0] m_all;
    assign m_ld_en  = o_ld_en[sel];
    assign m_ark0   = o_ark0[sel];
    assign m_ren    = o_ren[sel];
    assign m_final  = o_final[sel];
    assign m_dv     = o_dv[sel];
    assign m_busy   = o_busy[sel];
    assign m_ovr    = o_ovr[sel];
    assign m_ld_idx = o_ld_idx[sel];
    assign m_oidx   = o_oidx[sel];
    assign m_rnum   = o_rnum[sel];
    assign m_rcon   = o_rcon[sel];
    assign m_all    = {m_ld_en, m_ld_idx, m_ark0, m_ren, m_rnum, m_rcon,
                       m_final, m_oidx, m_dv, m_busy, m_ovr};

    logic [127:0] vec_pt [2];
    logic [127:0] vec_key[2];
    logic [127:0] vec_ct [2];
    logic [7:0]   sbox   [256];
    logic [7:0]   rcon_tab[11];
    logic [33:0]  exp_q[$];
    logic [33:0]  e;
    logic [127:0] st, kw;
    logic [31:0]  pt_w, key_w;
    int unsigned  n_vec = 0, n_err = 0;
    int cyc = 0, t4 = 0, last_evt = 0, n_ld = 0, n_ovr = 0, exp_rnd = 0, rc = 1;
    logic seen_dv = 1'b0, bp_seen = 1'b0, prev_hold = 1'b0;
    logic [1:0] prev_idx = 2'd0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcv);
        logic [31:0] t, w0, w1, w2, w3;
        w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcv, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] b [4][4];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[c][rr] = sbox[s[127 - 32*((c + rr) % 4) - 8*rr -: 8]];
        for (int c = 0; c < 4; c++) begin
            a0 = b[c][0]; a1 = b[c][1]; a2 = b[c][2]; a3 = b[c][3];
            if (fin) r[127 - 32*c -: 32] = {a0, a1, a2, a3};
            else     r[127 - 32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return r ^ k;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus behavioural datapath, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            n_ld = 0; seen_dv = 1'b0; prev_hold = 1'b0; bp_seen = 1'b0;
        end else begin
            rc = sel ? 4 : 1;
            if (prev_hold) begin
                chk("bp_hold_dv", m_dv, 1);
                chk("bp_hold_idx", m_oidx, prev_idx);
            end
            if (m_dv && !seen_dv) begin
                chk("first_dv_lat", cyc - t4, 2 + 10*rc);
                seen_dv = 1'b1;
            end
            if (m_dv && rdy) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_idx", m_oidx, e[33:32]);
                    chk("ct_word", st[127 - 32*int'(m_oidx) -: 32], e[31:0]);
                    if (m_oidx == 2'd3) begin
                        seen_dv = 1'b0;
                        if (!bp_seen) chk("last_xfer_lat", cyc - t4, 2 + 10*rc + 3);
                    end
                end
            end
            if (m_dv && !rdy) bp_seen = 1'b1;
            prev_hold = m_dv && !rdy;
            prev_idx  = m_oidx;
            if (m_ld_en) begin
                chk("ld_idx", m_ld_idx, n_ld[1:0]);
                st[127 - 32*int'(m_ld_idx) -: 32] = pt_w;
                kw[127 - 32*int'(m_ld_idx) -: 32] = key_w;
                n_ld++;
                if (n_ld[1:0] == 2'd0) t4 = cyc;
            end
            if (m_ark0) begin
                chk("ark0_lat", cyc - t4, 1);
                chk("ark0_rnum", m_rnum, 0);
                st = st ^ kw;
                last_evt = cyc; exp_rnd = 1; bp_seen = 1'b0;
            end
            if (m_ren) begin
                chk("rnd_gap", cyc - last_evt, rc);
                chk("rnd_num", m_rnum, exp_rnd);
                chk("rcon", m_rcon, (exp_rnd <= 10) ? rcon_tab[exp_rnd] : 8'h00);
                chk("final_sel", m_final, exp_rnd == 10);
                kw = key_step(kw, m_rcon);
                st = aes_round(st, kw, m_final);
                last_evt = cyc; exp_rnd++;
            end
            if (m_final) chk("final_only_r10", m_rnum, 10);
            if (m_ovr) n_ovr++;
        end
    end

    task automatic send_block(input int v, input int max_gap);
        int gap;
        for (int i = 0; i < 4; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; mp_dv = 1'b0; end
            @(posedge clk); #1;
            mp_dv = 1'b1;
            pt_w  = vec_pt[v][127 - 32*i -: 32];
            key_w = vec_key[v][127 - 32*i -: 32];
            if (i == 3)
                for (int j = 0; j < 4; j++) exp_q.push_back({2'(j), vec_ct[v][127 - 32*j -: 32]});
        end
        @(posedge clk); #1;
        mp_dv = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!m_busy) begin ok = 1'b1; break; end
        end
        chk("block_done", ok, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_rcon(input logic [7:0] v);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (m_rcon == v) begin ok = 1'b1; break; end
        end
        chk("wait_rcon", ok, 1);
    endtask

    task automatic wait_out_idx(input logic [1:0] v);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (m_dv && m_oidx == v) begin ok = 1'b1; break; end
        end
        chk("wait_out_idx", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0;
        vec_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        vec_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        vec_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vec_pt[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        vec_key[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vec_ct[1]  = 128'h3925841d02dc09fbdc118597196a0b32;
        rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r, s;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) begin inv = 8'(y); break; end
            r = inv; s = inv;
            for (int k = 0; k < 4; k++) begin r = {r[6:0], r[7]}; s = s ^ r; end
            sbox[x] = s ^ 8'h63;
        end
        st = '0; kw = '0; pt_w = '0; key_w = '0;

        rst_n = 1'b0; mp_dv = 1'b1; rdy = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", m_all, 0);
        mp_dv = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;

        // Single FIPS-197 C.1 block, ROUND_CYCLES=1.
        send_block(0, 0);
        wait_done();

        // Backpressure on word 1 for five cycles.
        send_block(1, 0);
        wait_out_idx(2'd0);
        @(posedge clk); #1 rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_idx", m_oidx, 1);
        chk("bp_dv", m_dv, 1);
        rdy = 1'b1;
        wait_done();

        // Overrun strobe during round 5.
        ld0 = n_ld;
        send_block(0, 0);
        wait_rcon(8'h08);
        @(posedge clk); #1 mp_dv = 1'b1;
        @(posedge clk); #1 mp_dv = 1'b0;
        @(negedge clk); chk("ovr_pulse", m_ovr, 1);
        @(negedge clk); chk("ovr_one_cycle", m_ovr, 0);
        chk("ovr_no_load", n_ld, ld0 + 4);
        wait_done();

        // Strobe on the final transfer is an overrun; next block starts the following cycle.
        send_block(1, 0);
        wait_out_idx(2'd2);
        @(posedge clk); #1 mp_dv = 1'b1;
        send_block(0, 0);
        wait_done();
        chk("ovr_count", n_ovr, 2);

        // Irregular strobe spacing.
        for (int b = 0; b < 3; b++) begin
            send_block(b % 2, 7);
            wait_done();
        end

        // ROUND_CYCLES=4 instance.
        sel = 1'b1;
        send_block(1, 0);
        wait_done();
        send_block(0, 3);
        wait_done();

        // Asynchronous reset during round 7, then a fresh block.
        send_block(1, 0);
        wait_rcon(8'h40);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", m_all, 0);
        @(negedge clk); @(negedge clk);
        chk("rst_flush", exp_q.size(), 0);
        #2 rst_n = 1'b1;
        send_block(0, 0);
        wait_done();
        chk("ovr_total", n_ovr, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
